// File: rtl/fdiv_axis.sv
// fdiv_axis: iterative binary32 divider (restoring, one quotient bit per cycle) with AXI4-Stream handshakes.
// Define FDIV_EARLY_SPECIAL_EN to route special-operand results straight from IDLE to OUT.
module fdiv_axis (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] s_axis_a_tdata,
   input  logic        s_axis_a_tvalid,
   output logic        s_axis_a_tready,
   input  logic [31:0] s_axis_b_tdata,
   input  logic        s_axis_b_tvalid,
   output logic        s_axis_b_tready,
   output logic [31:0] m_axis_result_tdata,
   output logic        m_axis_result_tvalid,
   input  logic        m_axis_result_tready
);
`ifdef FDIV_EARLY_SPECIAL_EN
   localparam logic EARLY = 1'b1;
`else
   localparam logic EARLY = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, DIV, ROUND, OUT} state_t;
   state_t state, state_nx;
   logic trdy, sign, spec;
   logic [31:0] spec_res;
   logic [9:0] exp_r;
   logic [23:0] mb;
   logic [25:0] rem;
   logic [24:0] quo;
   logic [4:0] cnt;
   logic [7:0] ea, eb;
   logic [23:0] ma_n, mb_n;
   logic za, zb, ia, ib, nan_n, special_n, sign_n, lt, accept, ge, up;
   logic [31:0] spec_n, res;
   logic [25:0] rsel;
   logic [23:0] mr;
   logic [9:0] er;
   assign s_axis_a_tready = trdy;
   assign s_axis_b_tready = trdy;
   assign ea = s_axis_a_tdata[30:23];
   assign eb = s_axis_b_tdata[30:23];
   assign za = ea == 8'd0;
   assign zb = eb == 8'd0;
   assign ia = ea == 8'hFF && s_axis_a_tdata[22:0] == 23'd0;
   assign ib = eb == 8'hFF && s_axis_b_tdata[22:0] == 23'd0;
   assign nan_n = (ea == 8'hFF && |s_axis_a_tdata[22:0]) || (eb == 8'hFF && |s_axis_b_tdata[22:0]) ||
                  (za && zb) || (ia && ib);
   assign special_n = za || zb || ea == 8'hFF || eb == 8'hFF;
   assign sign_n = s_axis_a_tdata[31] ^ s_axis_b_tdata[31];
   assign spec_n = nan_n ? 32'h7FC00000 : (zb || ia) ? {sign_n, 8'hFF, 23'd0} : {sign_n, 31'd0};
   assign ma_n = za ? 24'd0 : {1'b1, s_axis_a_tdata[22:0]};
   assign mb_n = zb ? 24'd0 : {1'b1, s_axis_b_tdata[22:0]};
   assign lt = ma_n < mb_n;
   assign accept = state == IDLE && trdy && s_axis_a_tvalid && s_axis_b_tvalid;
   assign ge = rem >= {2'b00, mb};
   assign rsel = ge ? rem - {2'b00, mb} : rem;
   // mantissa wraps to zero on round carry-out, i.e. the hidden bit clears
   assign up = quo[0] && (rem != 26'd0 || quo[1]);
   assign mr = quo[24:1] + {23'd0, up};
   assign er = exp_r + {9'd0, ~mr[23]};
   assign res = spec ? spec_res
              : $signed(er) >= 10'sd255 ? {sign, 8'hFF, 23'd0}
              : $signed(er) <= 10'sd0 ? {sign, 31'd0}
              : {sign, er[7:0], mr[22:0]};
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (EARLY && special_n) ? OUT : DIV;
         DIV:     if (cnt == 5'd0) state_nx = ROUND;
         ROUND:   state_nx = OUT;
         OUT:     if (m_axis_result_tvalid && m_axis_result_tready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         trdy <= 1'b0;
         m_axis_result_tvalid <= 1'b0;
         m_axis_result_tdata <= 32'd0;
         sign <= 1'b0;
         spec <= 1'b0;
         spec_res <= 32'd0;
         exp_r <= 10'd0;
         mb <= 24'd0;
         rem <= 26'd0;
         quo <= 25'd0;
         cnt <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               trdy <= !accept;
               if (accept) begin
                  sign <= sign_n;
                  spec <= special_n;
                  spec_res <= spec_n;
                  exp_r <= {2'b00, ea} - {2'b00, eb} + 10'd127 - {9'd0, lt};
                  mb <= mb_n;
                  rem <= lt ? {1'b0, ma_n, 1'b0} : {2'b00, ma_n};
                  quo <= 25'd0;
                  cnt <= 5'd24;
               end
            end
            DIV: begin
               rem <= rsel << 1;
               quo <= {quo[23:0], ge};
               cnt <= cnt - 5'd1;
            end
            ROUND: begin
               m_axis_result_tdata <= res;
               m_axis_result_tvalid <= 1'b1;
            end
            OUT: begin
               if (!m_axis_result_tvalid) begin
                  m_axis_result_tdata <= spec_res;
                  m_axis_result_tvalid <= 1'b1;
               end else if (m_axis_result_tready) begin
                  m_axis_result_tvalid <= 1'b0;
                  trdy <= 1'b1;
               end
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_fdiv_axis.sv
// tb_fdiv_axis: randomized and directed stimulus against a wide-integer-division reference model.
module tb_fdiv_axis;
`ifdef FDIV_EARLY_SPECIAL_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   logic aclk = 1'b0, aresetn = 1'b1;
   logic [31:0] a_data = 32'd0, b_data = 32'd0, r_data;
   logic a_valid = 1'b0, b_valid = 1'b0, a_rdy, b_rdy, r_valid, r_ready;
   logic rr_dir = 1'b1, rr_rand = 1'b1, rnd_rdy = 1'b0;
   int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
   logic [31:0] exp_q[$];
   int lat_q[$];
   bit inflight = 0, hs_prev = 0, prev_valid = 0;
   logic [31:0] last_res = 32'd0;
   logic [32:0] mm;
   assign r_ready = rnd_rdy ? rr_rand : rr_dir;
   fdiv_axis dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tready(a_rdy),
      .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tready(b_rdy),
      .m_axis_result_tdata(r_data), .m_axis_result_tvalid(r_valid), .m_axis_result_tready(r_ready)
   );
   always #5 aclk = ~aclk;
   initial forever begin @(posedge aclk); cyc++; end
   initial forever begin @(posedge aclk); #1 rr_rand = 1'($urandom_range(0, 1)); end
   initial begin #1000000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp_v);
      end
   endtask
   // Bit 32 flags a forced (special-operand) result; quotient taken from a 64-bit integer divide.
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
      int ea = int'(a[30:23]);
      int eb = int'(b[30:23]);
      logic s = a[31] ^ b[31];
      bit za = ea == 0, zb = eb == 0;
      bit ia = ea == 255 && a[22:0] == 23'd0, ib = eb == 255 && b[22:0] == 23'd0;
      bit na = ea == 255 && a[22:0] != 23'd0, nb = eb == 255 && b[22:0] != 23'd0;
      logic [63:0] num, den, q, r;
      logic [24:0] mant;
      int e, sh;
      bit g, st;
      if (na || nb || (za && zb) || (ia && ib)) return {1'b1, 32'h7FC00000};
      if (ia || zb) return {1'b1, s, 8'hFF, 23'd0};
      if (za || ib) return {1'b1, s, 31'd0};
      num = {40'd0, 1'b1, a[22:0]} << 40;
      den = {40'd0, 1'b1, b[22:0]};
      q = num / den;
      r = num % den;
      e = ea - eb + 127;
      if (q[40]) sh = 17;
      else begin sh = 16; e--; end
      mant = 25'(q >> sh);
      g = q[sh-1];
      st = (r != 64'd0) || ((q & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0);
      if (g && (st || mant[0])) mant++;
      if (mant[24]) begin mant = 25'h0800000; e++; end
      if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
      if (e <= 0) return {1'b0, s, 31'd0};
      return {1'b0, s, e[7:0], mant[22:0]};
   endfunction
   function automatic logic [31:0] rand_op();
      int k = $urandom_range(0, 9);
      logic [31:0] r = $urandom;
      if (k < 6) r[30:23] = 8'($urandom_range(60, 194));
      else if (k == 6) r[30:23] = 8'd0;
      else if (k == 7) begin
         r[30:23] = 8'hFF;
         if ($urandom_range(0, 1) == 1) r[22:0] = 23'd0;
      end else if (k == 8) r[22:0] = 23'd0;
      return r;
   endfunction
   always @(negedge aclk) begin
      if (!aresetn) begin
         check("rst_tvalid", r_valid, 0);
         check("rst_trdy", a_rdy | b_rdy, 0);
         exp_q.delete();
         lat_q.delete();
         inflight = 0;
         hs_prev = 0;
         prev_valid = 0;
      end else begin
         check("trdy_equal", b_rdy, a_rdy);
         if (hs_prev) begin
            check("post_hs_trdy", a_rdy, 1);
            check("post_hs_tvalid", r_valid, 0);
         end
         if (inflight) check("busy_trdy", a_rdy, 0);
         if (r_valid) begin
            check("tvalid_without_op", r_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
               check("tdata", r_data, exp_q[0]);
               if (!prev_valid) check("latency", 32'(cyc - acc_cyc), 32'(lat_q[0]));
            end
         end
         hs_prev = r_valid && r_ready;
         if (hs_prev && exp_q.size() != 0) begin
            last_res = r_data;
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            inflight = 0;
         end
         if (a_rdy && a_valid && b_valid) begin
            mm = model(a_data, b_data);
            exp_q.push_back(mm[31:0]);
            lat_q.push_back((EARLY && mm[32]) ? 1 : 26);
            acc_cyc = cyc + 1;
            inflight = 1;
         end
         prev_valid = r_valid;
      end
   end
   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      a_data = a;
      b_data = b;
      a_valid = 1'b1;
      b_valid = 1'b1;
      while (!a_rdy && n < 200) begin @(posedge aclk); #1; n++; end
      check("accept_timeout", 32'(n >= 200), 0);
      @(posedge aclk);
      #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask
   task automatic wait_done();
      int n = 0;
      while ((inflight || r_valid) && n < 400) begin @(posedge aclk); #1; n++; end
      check("done_timeout", 32'(n >= 400), 0);
   endtask
   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit, input string name);
      logic [32:0] m = model(a, b);
      check({name, "_model"}, m[31:0], lit);
      send(a, b);
      wait_done();
      check(name, last_res, lit);
   endtask
   initial begin
      int n;
      #2 aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      check("reset_tdata", r_data, 0);
      check("reset_tvalid", r_valid, 0);
      check("reset_trdy", a_rdy, 0);
      @(posedge aclk);
      #3 aresetn = 1'b1;
      #1 check("trdy_before_edge", a_rdy, 0);
      @(posedge aclk);
      #1 check("trdy_after_release", a_rdy, 1);
      a_data = 32'h40C00000;
      a_valid = 1'b1;
      repeat (5) begin @(posedge aclk); #1; end
      check("a_only_no_accept", a_rdy, 1);
      a_valid = 1'b0;
      run(32'h40C00000, 32'h40000000, 32'h40400000, "div_6_2");
      run(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "div_1_3");
      run(32'h3F800000, 32'h3F800000, 32'h3F800000, "div_1_1");
      run(32'h3F800000, 32'h00000000, 32'h7F800000, "one_by_zero");
      run(32'h80000000, 32'h00000000, 32'h7FC00000, "zero_by_zero");
      run(32'h7F800000, 32'hC0000000, 32'hFF800000, "inf_by_neg2");
      run(32'h7F000000, 32'h3E800000, 32'h7F800000, "overflow");
      run(32'h00800000, 32'h40000000, 32'h00000000, "underflow");
      run(32'h3F800000, 32'h7F800000, 32'h00000000, "fin_by_inf");
      run(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in");
      rr_dir = 1'b0;
      send(32'h40C00000, 32'h40000000);
      n = 0;
      while (!r_valid && n < 100) begin @(posedge aclk); #1; n++; end
      check("bp_wait_timeout", 32'(n >= 100), 0);
      repeat (10) begin
         @(posedge aclk);
         #1;
         check("bp_valid", r_valid, 1);
         check("bp_stable", r_data, 32'h40400000);
         check("bp_trdy", a_rdy | b_rdy, 0);
      end
      rr_dir = 1'b1;
      @(posedge aclk);
      #1;
      check("bp_release_valid", r_valid, 0);
      check("bp_release_trdy", a_rdy, 1);
      send(32'h40C00000, 32'h40000000);
      repeat (10) @(posedge aclk);
      #1 aresetn = 1'b0;
      #1;
      check("abort_tvalid", r_valid, 0);
      check("abort_trdy", a_rdy | b_rdy, 0);
      repeat (2) @(posedge aclk);
      #3 aresetn = 1'b1;
      @(posedge aclk);
      #1 check("abort_trdy_back", a_rdy, 1);
      check("abort_no_result", r_valid, 0);
      run(32'h40C00000, 32'h40000000, 32'h40400000, "after_abort");
      rnd_rdy = 1'b1;
      for (int i = 0; i < 40; i++) send(rand_op(), rand_op());
      wait_done();
      rnd_rdy = 1'b0;
      wait_done();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
